// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the instruction/data memory port arbiter.
// Counter widths are sized for the largest supported latency and starvation limit.
package mem_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;

  localparam int MEM_LAT_MAX    = 7;
  localparam int STARVE_MAX_LIM = 15;

  // Sized for MEM_LAT_MAX so lat_cnt can reach any legal MEM_LAT value.
  localparam int LAT_W    = $clog2(MEM_LAT_MAX + 1);
  localparam int STARVE_W = $clog2(STARVE_MAX_LIM + 1);

endpackage

// File: rtl/mem_lat_tracker.sv
// Tracks the single outstanding memory access: latency count, owning port,
// load/store kind and whether a flushed fetch response must be dropped.
module mem_lat_tracker
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   start,
  input  owner_t start_owner,
  input  logic   start_store,
  input  logic   flush,
  output logic   resp_cycle,
  output owner_t resp_owner,
  output logic   resp_store,
  output logic   resp_drop
);

  localparam logic [LAT_W-1:0] LAT_END = LAT_W'(MEM_LAT);

  logic [LAT_W-1:0] lat_cnt;
  owner_t           owner;
  logic             store;
  logic             drop;

  // lat_cnt==0 means nothing outstanding; a new start overrides the response-cycle wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_cnt <= '0;
      owner   <= OWN_IF;
      store   <= 1'b0;
      drop    <= 1'b0;
    end else if (start) begin
      lat_cnt <= LAT_W'(1);
      owner   <= start_owner;
      store   <= start_store;
      drop    <= (start_owner == OWN_IF) && flush;
    end else begin
      if (lat_cnt == LAT_END) begin
        lat_cnt <= '0;
      end else if (lat_cnt != '0) begin
        lat_cnt <= lat_cnt + LAT_W'(1);
      end
      if (flush && (owner == OWN_IF) && (lat_cnt != '0)) begin
        drop <= 1'b1;
      end
    end
  end

  always_comb begin
    resp_cycle = (lat_cnt == LAT_END);
    resp_owner = owner;
    resp_store = store;
    resp_drop  = drop | flush;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and
// load/store, with starvation protection for fetch and flush-aware responses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  arb_state_t          state, state_nxt;
  logic [STARVE_W-1:0] starve_cnt;
  logic                window, if_win, d_win, grant;
  owner_t              win_owner;
  logic                resp_cycle, resp_store, resp_drop;
  owner_t              resp_owner;

  mem_lat_tracker #(
    .MEM_LAT(MEM_LAT)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .start      (grant),
    .start_owner(win_owner),
    .start_store(d_win & d_we),
    .flush      (if_flush),
    .resp_cycle (resp_cycle),
    .resp_owner (resp_owner),
    .resp_store (resp_store),
    .resp_drop  (resp_drop)
  );

  // Grant window is IDLE or the response cycle, which allows back-to-back issue.
  always_comb begin
    window    = !reset && ((state == IDLE) || resp_cycle);
    if_win    = window && if_req && (!d_req || (starve_cnt == STARVE_LIM));
    d_win     = window && d_req && !if_win;
    grant     = if_win | d_win;
    win_owner = d_win ? OWN_D : OWN_IF;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = BUSY;
      BUSY:    if (resp_cycle && !grant) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (if_win || !if_req) begin
      starve_cnt <= '0;
    end else if (d_win && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  // Memory strobe and response steering; everything is forced low under reset.
  always_comb begin
    if_gnt    = if_win;
    d_gnt     = d_win;
    mem_en    = grant;
    mem_we    = d_win & d_we;
    mem_addr  = d_win ? d_addr : (if_win ? if_addr : '0);
    mem_wdata = (d_win && d_we) ? d_wdata : '0;

    if_rvalid = !reset && resp_cycle && (resp_owner == OWN_IF) && !resp_drop;
    d_rvalid  = !reset && resp_cycle && (resp_owner == OWN_D);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = (d_rvalid && !resp_store) ? mem_rdata : '0;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the instruction-fetch path (PC/instr) and the load/store path (MemRead/MemWrite from the decoder).
- Arbitrates the two requesters and tracks the single outstanding access through a fixed memory latency.
- Returns responses to the owning port and discards stale fetches when a branch flushes the front end.
- Provides the stall source for both pipeline ends.

Parameters:
- ADDR_W, 16, address width for both requesters and the memory.
- DATA_W, 32, data width; fetch consumes bits [15:0].
- MEM_LAT, 2, cycles from mem_en to valid mem_rdata; legal range 1..7.
- STARVE_MAX, 4, consecutive lost arbitrations after which fetch is forced to win; legal range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held stable until if_gnt
- if_addr  in  ADDR_W  fetch address (PC)
- if_flush  in  1  branch taken; drop any in-flight fetch response
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DATA_W  fetch data
- d_req  in  1  load/store request; held stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid / store complete
- d_rdata  out  DATA_W  load data; 0 for stores
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset:
  - State goes to IDLE; lat_cnt, starve_cnt, owner and drop all clear to 0.
  - While reset is high, every output is 0 (gnt, rvalid, rdata, mem_*).
  - Reset mid-access discards the outstanding response; mem_rdata is ignored.
- FSM states:
  - IDLE: nothing outstanding.
  - BUSY: one access outstanding; lat_cnt counts 1..MEM_LAT.
- Grant window: a grant is allowed when the state is IDLE, or BUSY with lat_cnt==MEM_LAT (the response cycle). This gives back-to-back issue, one access per MEM_LAT cycles.
- Arbitration inside a grant window:
  - Data wins by default.
  - Fetch wins if starve_cnt==STARVE_MAX.
  - The winner's gnt is combinational (Mealy).
  - mem_en/mem_we/mem_addr/mem_wdata are driven combinationally from the winner in the same cycle. mem_we=d_we for data and 0 for fetch.
- Starvation counter:
  - Increments when if_req=1 and data wins a window.
  - Clears on if_gnt or when if_req=0.
  - Saturates at STARVE_MAX.
- Transitions:
  - A grant sets state BUSY, lat_cnt=1, owner=winner, drop=0.
  - In BUSY, lat_cnt increments each cycle.
  - At lat_cnt==MEM_LAT: the response is emitted. State stays BUSY (lat_cnt=1) if a new grant occurs that cycle; otherwise it returns to IDLE.
- Response cycle:
  - Owner data: d_rvalid=1; d_rdata=mem_rdata for a load, 0 for a store.
  - Owner fetch with drop=0: if_rvalid=1, if_rdata=mem_rdata.
  - rvalid is a single-cycle pulse.
- Flush:
  - if_flush while a fetch is outstanding (including the grant cycle itself) sets drop=1. The response is then suppressed, but the memory slot is still consumed.
  - if_flush does not affect outstanding data accesses.
  - if_flush in the response cycle suppresses that cycle's if_rvalid.
  - A fetch granted in the same cycle as the flush is also dropped.
- Simultaneous if_req and d_req in IDLE: data is granted first; fetch gets the next grant window unless new data arrives.
- No grant in a window: both gnts 0, mem_en=0.
- At most one outstanding access; no queueing.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t {IDLE, BUSY}
  - owner_t {OWN_IF, OWN_D}
  - width-derived constant LAT_W = $clog2(MEM_LAT+1)
- One sub-module, mem_lat_tracker: holds lat_cnt, owner and drop; outputs resp_cycle, resp_owner and resp_drop.
- Arbitration, starvation counting and the FSM live in mem_port_arbiter.

Test Plan (MEM_LAT=2, STARVE_MAX=4):
- Single fetch: if_req=1, if_addr=0x0010 at c0 -> if_gnt=1 and mem_en=1, mem_addr=0x0010, mem_we=0 at c0; mem_rdata=0x00002005 at c2 -> if_rvalid=1, if_rdata=0x00002005 at c2.
- Contention: if_req and d_req (load, 0x0100) at c0 -> d_gnt c0; d_rvalid plus if_gnt at c2; if_rvalid at c4.
- Starvation: d_req and if_req held high continuously -> d_gnt at c0, c2, c4, c6; if_gnt at c8 (starve_cnt=4); d_gnt at c10.
- Flush: fetch granted c0, if_flush=1 at c1 -> if_rvalid=0 at c2; a pending d_req is granted at c2.
- Store: d_req, d_we=1, d_addr=0x0200, d_wdata=0xDEADBEEF at c0 -> mem_we=1, mem_wdata=0xDEADBEEF at c0; d_rvalid=1, d_rdata=0 at c2.
- Reset mid-access: fetch granted c0, reset=1 at c1 -> all outputs 0 at c1; if_rvalid=0 at c2; reset=0 with if_req=1 at c3 -> if_gnt at c3.
